// File: rtl/enc_bin2onehot_pipe.sv
// Registered binary-to-one-hot/thermometer encoder behind a 2-entry valid/ready FIFO.
// Out-of-range codes produce an all-zero vector tagged with err and are counted.
module enc_bin2onehot_pipe #(
    parameter int IN_W      = 4,
    parameter int OUT_W     = 15,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [IN_W:0] OUT_W_EXT = (IN_W + 1)'(OUT_W);

    logic [IN_W:0]          w_idx;
    logic                   w_err;
    logic [OUT_W-1:0]       w_enc;
    logic                   w_push;
    logic                   w_pop;

    logic [OUT_W-1:0]       r_data [2];
    logic                   r_err  [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    // Widen by one bit so OUT_W = 2^IN_W compares correctly.
    assign w_idx = {1'b0, in};
    assign w_err = (w_idx >= OUT_W_EXT);

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_enc
            localparam logic [IN_W:0] BIT_IDX = (IN_W + 1)'(gi);
            assign w_enc[gi] = !w_err &&
                               (mode ? (BIT_IDX <= w_idx) : (BIT_IDX == w_idx));
        end
    endgenerate

    assign in_ready  = !rst && (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data[gi] <= '0;
                    r_err[gi]  <= 1'b0;
                end else if (w_push && (r_wr_ptr == 1'(gi))) begin
                    r_data[gi] <= w_enc;
                    r_err[gi]  <= w_err;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push && w_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    // Head is masked to zero when empty so stale slot contents never leak out.
    assign out     = out_valid ? r_data[r_rd_ptr] : '0;
    assign out_err = out_valid ? r_err[r_rd_ptr]  : 1'b0;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Directed bench for enc_bin2onehot_pipe: reset, one-hot, thermometer, error
// counting/saturation, backpressure and mid-operation reset.
module tb_enc_bin2onehot_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in;
    logic        mode;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        in_ready2;
    logic        out_valid2;
    logic [14:0] out2;
    logic        out_err2;
    logic [1:0]  err_cnt2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in(in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .out_err(out_err), .err_cnt(err_cnt)
    );

    enc_bin2onehot_pipe #(.IN_W(4), .OUT_W(15), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in(in), .mode(mode), .out_valid(out_valid2), .out_ready(out_ready),
        .out(out2), .out_err(out_err2), .err_cnt(err_cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one code into an empty buffer with out_ready=1, check it, then check drain.
    task automatic push_and_see(input logic [3:0] code, input logic m,
                                input logic [14:0] exp_out, input logic exp_err);
        in_valid  = 1'b1;
        in        = code;
        mode      = m;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq($sformatf("valid in=%0d m=%0d", code, m), 32'(out_valid), 32'd1);
        check_eq($sformatf("out in=%0d m=%0d", code, m), 32'(out), 32'(exp_out));
        check_eq($sformatf("err in=%0d m=%0d", code, m), 32'(out_err), 32'(exp_err));
        tick();
        check_eq("drained", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in        = 4'd3;
        mode      = 1'b0;
        out_ready = 1'b1;

        // Reset held two cycles with in_valid high.
        for (int c = 0; c < 2; c++) begin
            tick();
            check_eq($sformatf("rst%0d in_ready", c), 32'(in_ready), 32'd0);
            check_eq($sformatf("rst%0d out_valid", c), 32'(out_valid), 32'd0);
            check_eq($sformatf("rst%0d out", c), 32'(out), 32'd0);
            check_eq($sformatf("rst%0d err_cnt", c), 32'(err_cnt), 32'd0);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("post-rst in_ready", 32'(in_ready), 32'd1);

        // One-hot sweep, one code per cycle.
        in_valid = 1'b1;
        mode     = 1'b0;
        for (int k = 0; k < 15; k++) begin
            in = 4'(k);
            #1;
            check_eq($sformatf("sweep%0d in_ready", k), 32'(in_ready), 32'd1);
            tick();
            check_eq($sformatf("sweep%0d out", k), 32'(out), 32'd1 << k);
            check_eq($sformatf("sweep%0d err", k), 32'(out_err), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        check_eq("sweep drained", 32'(out_valid), 32'd0);

        // Thermometer.
        push_and_see(4'd0,  1'b1, 15'h0001, 1'b0);
        push_and_see(4'd5,  1'b1, 15'h003F, 1'b0);
        push_and_see(4'd14, 1'b1, 15'h7FFF, 1'b0);

        // Out-of-range in both modes.
        push_and_see(4'd15, 1'b0, 15'h0000, 1'b1);
        push_and_see(4'd15, 1'b1, 15'h0000, 1'b1);
        check_eq("err_cnt after 2", 32'(err_cnt), 32'd2);
        check_eq("sat err_cnt after 2", 32'(err_cnt2), 32'd2);
        for (int k = 0; k < 3; k++) begin
            push_and_see(4'd15, 1'(k), 15'h0000, 1'b1);
        end
        check_eq("err_cnt after 5", 32'(err_cnt), 32'd5);
        check_eq("sat err_cnt after 5", 32'(err_cnt2), 32'd3);

        // Backpressure: fill with 3 then 7, offer a third code.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 1'b0;
        in        = 4'd3;
        tick();
        in = 4'd7;
        tick();
        check_eq("bp full in_ready", 32'(in_ready), 32'd0);
        check_eq("bp head", 32'(out), 32'h0008);
        in = 4'd9;
        tick();
        check_eq("bp hold out", 32'(out), 32'h0008);
        check_eq("bp hold valid", 32'(out_valid), 32'd1);
        check_eq("bp still full", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("bp second", 32'(out), 32'h0080);
        check_eq("bp in_ready back", 32'(in_ready), 32'd1);
        tick();
        check_eq("bp no third", 32'(out_valid), 32'd0);

        // Reset with a full buffer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in        = 4'd1;
        tick();
        in = 4'd2;
        tick();
        check_eq("pre-rst full", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check_eq("mid-rst out_valid", 32'(out_valid), 32'd0);
        check_eq("mid-rst out", 32'(out), 32'd0);
        check_eq("mid-rst err_cnt", 32'(err_cnt), 32'd0);
        check_eq("mid-rst in_ready", 32'(in_ready), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("after rst in_ready", 32'(in_ready), 32'd1);
        tick();
        check_eq("no stale", 32'(out_valid), 32'd0);
        push_and_see(4'd4, 1'b0, 15'h0010, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/enc_bin2onehot_pipe.md
Name: enc_bin2onehot_pipe

Overview:
Parametrised, registered binary-to-one-hot / thermometer encoder with valid/ready flow control on both sides. A 2-entry output buffer decouples the producer from a stalling consumer. Out-of-range codes are flagged and counted instead of silently producing zero. It replaces the fixed 4-bit combinational encoder wherever a decoded select must cross a backpressured pipeline stage.

Parameters:
IN_W, 4, width of binary input code
OUT_W, 15, number of decoded output lines; legal range 1..2^IN_W
ERR_CNT_W, 8, width of saturating out-of-range event counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  input code valid
in_ready  output  1  block can accept a code this cycle
in  input  IN_W  binary code
mode  input  1  sampled with each accepted code: 0 = one-hot, 1 = thermometer
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry
out  output  OUT_W  encoded vector of head entry
out_err  output  1  head entry came from an out-of-range code
err_cnt  output  ERR_CNT_W  saturating count of accepted out-of-range codes

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset (rst=1 at a clk edge): buffer count=0, out_valid=0, out=0, out_err=0, err_cnt=0. While rst=1, in_ready=0. Reset mid-transfer discards all buffered entries; no partial output.
- Encode, applied at acceptance time using that cycle's in/mode:
  - in < OUT_W, mode=0: out[i] = (i == in); exactly one bit set. in=0 gives out[0]=1.
  - in < OUT_W, mode=1: out[i] = (i <= in). in=0 gives 1 bit set; in=OUT_W-1 gives all ones.
  - in >= OUT_W, either mode: out = all zeros, err=1.
  - Unsigned compare at IN_W bits. When OUT_W = 2^IN_W, err never occurs.
- Buffer: 2-entry FIFO of {out, err}.
  - count in 0..2.
  - in_ready = !rst && (count != 2); combinational from count only, never from out_ready.
  - Push when in_valid && in_ready.
  - out_valid = (count != 0); out/out_err show the head entry.
  - When out_valid=0, out=0 and out_err=0.
  - Pop when out_valid && out_ready.
- Latency: a code accepted at edge N appears with out_valid=1 after edge N, when the buffer was empty. Throughput is 1 code/cycle while out_ready stays 1.
- Simultaneous events:
  - count=0, push only: count becomes 1.
  - count=1, push+pop: count stays 1; new entry becomes head after the edge.
  - count=2: no push possible; a pop makes count 1.
  - Ordering is strictly FIFO.
- Stability: while out_valid=1 && out_ready=0, out and out_err hold unchanged.
- in/mode are ignored when in_valid=0 or in_ready=0.
- err_cnt increments by 1 on each push with err=1 and saturates at 2^ERR_CNT_W-1. It is cleared only by rst.
- No combinational path from in/in_valid to out/out_valid. The only combinational output is in_ready, derived from count and rst.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out=0, err_cnt=0 throughout. First cycle after release: in_ready=1.
- One-hot sweep, mode=0, out_ready=1, in=0..14 back-to-back -> one code/cycle; out = 15'h0001, 15'h0002, ... 15'h4000 in order, each 1 cycle after accept; out_err=0.
- Thermometer, mode=1: in=0 -> out=15'h0001; in=5 -> 15'h003F; in=14 -> 15'h7FFF.
- Out-of-range: in=15 with mode 0 and then mode 1 -> out=0, out_err=1, err_cnt=2. With ERR_CNT_W=2, 5 bad codes -> err_cnt=3 (saturated).
- Backpressure: out_ready=0, push in=3 then in=7 -> count=2, in_ready=0, a third code is not accepted, out holds 15'h0008. Raise out_ready -> outputs 15'h0008 then 15'h0080, and in_ready returns to 1 after the first pop.
- Reset mid-operation: buffer full, assert rst 1 cycle -> out_valid=0, err_cnt=0; stale entries never appear afterwards.
